// File: rtl/dea_stream_sequencer_if.sv
// Stream and DEA-side signals of the DEA stream sequencer.
// The slave modport is the sequencer's view; master is the surrounding system's view.
interface dea_stream_sequencer_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       dea_reset;
    logic       dea_kset;
    logic [7:0] dea_din;
    logic       dea_step;
    logic [7:0] dea_dout;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;

    modport slave (
        input  s_valid, s_data, m_ready, dea_dout,
        output s_ready, dea_reset, dea_kset, dea_din, dea_step, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, m_ready, dea_dout,
        input  s_ready, dea_reset, dea_kset, dea_din, dea_step, m_valid, m_data
    );
endinterface

// File: rtl/dea_stream_sequencer.sv
// Feeds a framed key/message byte stream into the DEA cipher one step per accepted byte
// and collects the ciphertext into an output FIFO with valid/ready back-pressure.
module dea_stream_sequencer #(
    parameter int unsigned DEA_LAT    = 1,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LEN_W      = 24,
    parameter int unsigned KEY_MAX    = 4
) (
    input  logic                     dclk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [2:0]               key_len,
    input  logic [LEN_W-1:0]         msg_len,
    dea_stream_sequencer_if.slave    bus,
    output logic                     busy,
    output logic                     done
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [2:0] {StIdle, StDrst, StKey, StMsg, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [2:0]         key_len_q, key_cnt_q;
    logic [LEN_W-1:0]   msg_len_q, msg_cnt_q;
    logic [7:0]         din_q;
    logic               step_q, kset_q;
    logic [DEA_LAT-1:0] lat_q;
    logic [CntW-1:0]    inflight_q, count_q;
    logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic       s_ready_c, accept, msg_acc, push, pop, credit_ok;
    logic [2:0] key_len_clamped;

    assign key_len_clamped = (32'(key_len) > KEY_MAX) ? 3'(KEY_MAX) : key_len;

    // DEA_LAT slots stay reserved so a byte already inside DEA always has a home.
    assign credit_ok = (32'(count_q) + 32'(inflight_q) + DEA_LAT) < FIFO_DEPTH;

    assign accept  = bus.s_valid & s_ready_c;
    assign msg_acc = accept & (state_q == StMsg);
    assign push    = lat_q[DEA_LAT-1];
    assign pop     = (count_q != '0) & bus.m_ready;

    always_comb begin
        state_d   = state_q;
        s_ready_c = 1'b0;
        case (state_q)
            StIdle:  if (start) state_d = StDrst;
            StDrst: begin
                if (key_len_q != 3'd0)        state_d = StKey;
                else if (msg_len_q == '0)     state_d = StDrain;
                else                          state_d = StMsg;
            end
            StKey: begin
                s_ready_c = 1'b1;
                if (bus.s_valid && key_cnt_q == key_len_q - 3'd1) begin
                    state_d = (msg_len_q == '0) ? StDrain : StMsg;
                end
            end
            StMsg: begin
                s_ready_c = credit_ok;
                if (bus.s_valid && credit_ok && msg_cnt_q == msg_len_q - LEN_W'(1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: if (inflight_q == '0 && count_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge dclk) begin
        if (!reset) begin
            state_q    <= StIdle;
            key_len_q  <= '0;
            key_cnt_q  <= '0;
            msg_len_q  <= '0;
            msg_cnt_q  <= '0;
            din_q      <= '0;
            step_q     <= 1'b0;
            kset_q     <= 1'b0;
            lat_q      <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start) begin
                key_len_q <= key_len_clamped;
                msg_len_q <= msg_len;
                key_cnt_q <= '0;
                msg_cnt_q <= '0;
            end
            if (accept && state_q == StKey) key_cnt_q <= key_cnt_q + 3'd1;
            if (msg_acc)                    msg_cnt_q <= msg_cnt_q + LEN_W'(1);
            step_q <= accept;
            // kset travels with the byte it describes, one cycle behind the state.
            kset_q <= (state_q == StKey);
            if (accept) din_q <= bus.s_data;
            lat_q      <= DEA_LAT'({lat_q, step_q & ~kset_q});
            inflight_q <= inflight_q + CntW'(msg_acc) - CntW'(push);
            count_q    <= count_q + CntW'(push) - CntW'(pop);
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge dclk) begin
        if (reset && push) mem_q[wr_ptr_q] <= bus.dea_dout;
    end

    assign bus.s_ready   = s_ready_c;
    assign bus.dea_reset = ~reset | (state_q == StDrst);
    assign bus.dea_kset  = kset_q;
    assign bus.dea_din   = din_q;
    assign bus.dea_step  = step_q;
    assign bus.m_valid   = (count_q != '0);
    assign bus.m_data    = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
endmodule

// File: tb/tb_dea_stream_sequencer.sv
// Directed bench for dea_stream_sequencer with an XOR stand-in for the DEA cipher.
module tb_dea_stream_sequencer;
    localparam int unsigned DEA_LAT    = 1;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned LEN_W      = 24;
    localparam int unsigned KEY_MAX    = 4;

    logic             dclk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       key_len = '0;
    logic [LEN_W-1:0] msg_len = '0;
    logic             busy, done;

    dea_stream_sequencer_if bus();

    dea_stream_sequencer #(
        .DEA_LAT(DEA_LAT), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W), .KEY_MAX(KEY_MAX)
    ) dut (
        .dclk(dclk), .reset(reset), .start(start), .key_len(key_len), .msg_len(msg_len),
        .bus(bus), .busy(busy), .done(done)
    );

    always #5 dclk = ~dclk;

    typedef struct {
        logic [2:0]  klen;
        logic [31:0] key;   // byte i at bits [8i+:8]
        int          mlen;
        logic [31:0] msg;
        logic [31:0] expd;
    } vec_t;

    vec_t       vecs [6];
    int         n_cmp = 0, n_fail = 0;
    int         ksteps, psteps, step_err, donecnt, sent_at_hold, mvalid_cycles;
    int         last_acc_cyc, done_cyc;
    logic       sready_at_hold;
    bit         acc_prev = 1'b0;
    logic [7:0] tx [$];
    logic [7:0] rx [$];
    logic [7:0] expq [$];
    logic [7:0] keym [4];
    int         kcnt = 0, midx = 0;

    // DEA stand-in: key bytes are loaded on kset steps, message bytes XOR the key cyclically.
    always @(posedge dclk) begin
        if (bus.dea_reset) begin
            kcnt = 0;
            midx = 0;
            bus.dea_dout <= 8'h00;
        end else if (bus.dea_step) begin
            if (bus.dea_kset) begin
                if (kcnt < 4) keym[kcnt] = bus.dea_din;
                kcnt++;
            end else begin
                bus.dea_dout <= bus.dea_din ^ ((kcnt == 0) ? 8'h00 : keym[midx % kcnt]);
                midx++;
            end
        end
    end

    always @(negedge dclk) begin
        if (bus.dea_step) begin
            if (bus.dea_kset) ksteps++;
            else              psteps++;
        end
        if (reset && (bus.dea_step !== acc_prev)) step_err++;
        acc_prev = reset & bus.s_valid & bus.s_ready;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
        end
    endtask

    task automatic run_frame(input logic [2:0] kl, input int mlen, input bit toggle,
                             input int hold, input int restart_at);
        int idx = 0;
        bit fin = 1'b0;
        rx.delete();
        ksteps = 0; psteps = 0; step_err = 0; donecnt = 0; mvalid_cycles = 0;
        sent_at_hold = -1; sready_at_hold = 1'b1; last_acc_cyc = -1; done_cyc = -1;
        @(posedge dclk); #1;
        start = 1'b1; key_len = kl; msg_len = LEN_W'(mlen);
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            @(posedge dclk); #1;
            start = (cyc == restart_at);
            if (start) begin key_len = 3'd0; msg_len = LEN_W'(1); end
            bus.s_valid = (idx < tx.size()) && (!toggle || (cyc % 2 == 0));
            bus.s_data  = (idx < tx.size()) ? tx[idx] : 8'h00;
            bus.m_ready = (cyc >= hold);
            @(negedge dclk);
            if (bus.s_valid && bus.s_ready) begin idx++; last_acc_cyc = cyc; end
            if (bus.m_valid) mvalid_cycles++;
            if (bus.m_valid && bus.m_ready) rx.push_back(bus.m_data);
            if (cyc == hold - 1) begin sent_at_hold = idx; sready_at_hold = bus.s_ready; end
            if (done) begin donecnt++; done_cyc = cyc; fin = 1'b1; end
        end
        @(posedge dclk); #1;
        start = 1'b0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
        check("frame_finished", 32'(fin), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge dclk);
            if (k == 0) check("idle_after_done", 32'(busy), 32'd0);
            if (done) donecnt++;
        end
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_out_count"}, 32'(rx.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            check($sformatf("%s_out_byte%0d", tag, i),
                  (i < rx.size()) ? 32'(rx[i]) : 32'hFFFF_FFFF, 32'(expq[i]));
        end
    endtask

    task automatic load_vec(input vec_t v);
        logic [31:0] k, m, e;
        k = v.key; m = v.msg; e = v.expd;
        tx.delete(); expq.delete();
        for (int i = 0; i < int'(v.klen); i++) tx.push_back(k[8*i +: 8]);
        for (int i = 0; i < v.mlen; i++) begin
            tx.push_back(m[8*i +: 8]);
            expq.push_back(e[8*i +: 8]);
        end
    endtask

    task automatic frame_checks(input string tag, input int kl, input int ml);
        compare_rx(tag);
        check({tag, "_done_pulses"}, 32'(donecnt), 32'd1);
        check({tag, "_key_steps"}, 32'(ksteps), 32'(kl));
        check({tag, "_msg_steps"}, 32'(psteps), 32'(ml));
        check({tag, "_step_follows_accept"}, 32'(step_err), 32'd0);
    endtask

    initial begin
        int got;
        vecs[0] = '{3'd4, 32'hAAAAAAAA, 3, 32'h00221100, 32'h0088BBAA};
        vecs[1] = '{3'd4, 32'h04030201, 4, 32'h40302010, 32'h44332211};
        vecs[2] = '{3'd2, 32'h0000F00F, 4, 32'hFFFF0000, 32'h0FF0F00F};
        vecs[3] = '{3'd0, 32'h00000000, 2, 32'h00003412, 32'h00003412};
        vecs[4] = '{3'd1, 32'h00000055, 3, 32'h0000AA55, 32'h0055FF00};
        vecs[5] = '{3'd3, 32'h00040201, 4, 32'h00000000, 32'h01040201};

        bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.m_ready = 1'b0;
        repeat (3) @(posedge dclk);
        @(negedge dclk);
        check("rst_dea_reset", 32'(bus.dea_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("rst_dea_step", 32'(bus.dea_step), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge dclk); #1 reset = 1'b1;
        @(negedge dclk);
        check("post_rst_dea_reset", 32'(bus.dea_reset), 32'd0);

        // Table of whole frames, full throughput.
        for (int v = 0; v < 6; v++) begin
            load_vec(vecs[v]);
            run_frame(vecs[v].klen, vecs[v].mlen, 1'b0, 0, -1);
            frame_checks($sformatf("vec%0d", v), int'(vecs[v].klen), vecs[v].mlen);
        end

        // Input valid toggling every cycle: no step on bubbles, no key-index slip.
        load_vec(vecs[2]);
        run_frame(vecs[2].klen, vecs[2].mlen, 1'b1, 0, -1);
        frame_checks("toggle", int'(vecs[2].klen), vecs[2].mlen);

        // Key only, empty message.
        tx.delete(); expq.delete();
        repeat (4) tx.push_back(8'hAA);
        run_frame(3'd4, 0, 1'b0, 0, -1);
        frame_checks("nomsg", 4, 0);
        check("nomsg_m_valid_cycles", 32'(mvalid_cycles), 32'd0);
        check("nomsg_done_latency", 32'(done_cyc - last_acc_cyc), 32'd2);

        // Consumer stalled: credit stops input, then everything drains in order.
        tx.delete(); expq.delete();
        for (int i = 0; i < 32; i++) begin tx.push_back(8'(i * 7 + 3)); expq.push_back(8'(i * 7 + 3)); end
        run_frame(3'd0, 32, 1'b0, 40, -1);
        check("stall_accepted", 32'(sent_at_hold), 32'(FIFO_DEPTH - DEA_LAT));
        check("stall_s_ready", 32'(sready_at_hold), 32'd0);
        frame_checks("stall", 0, 32);

        // key_len above KEY_MAX clamps; start during MSG is ignored.
        tx.delete(); expq.delete();
        tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h01, 8'h02};
        expq = '{8'h10, 8'h20};
        run_frame(3'd7, 2, 1'b0, 0, 6);
        frame_checks("clamp", 4, 2);

        // Reset mid-message after 5 of 10 bytes, then a clean frame.
        got = 0;
        @(posedge dclk); #1;
        start = 1'b1; key_len = 3'd0; msg_len = LEN_W'(10);
        for (int cyc = 0; cyc < 50 && got < 5; cyc++) begin
            @(posedge dclk); #1;
            start = 1'b0; bus.s_valid = 1'b1; bus.s_data = 8'(got + 8'h30); bus.m_ready = 1'b0;
            @(negedge dclk);
            if (bus.s_valid && bus.s_ready) got++;
        end
        check("mid_rst_bytes_in", 32'(got), 32'd5);
        @(posedge dclk); #1;
        bus.s_valid = 1'b0; reset = 1'b0;
        @(negedge dclk);
        check("mid_rst_dea_reset", 32'(bus.dea_reset), 32'd1);
        @(posedge dclk); #1 reset = 1'b1;
        @(negedge dclk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("mid_rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("mid_rst_dea_step", 32'(bus.dea_step), 32'd0);
        load_vec(vecs[1]);
        run_frame(vecs[1].klen, vecs[1].mlen, 1'b0, 0, -1);
        frame_checks("after_rst", int'(vecs[1].klen), vecs[1].mlen);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
